// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// regfile_pkg : shared constants and FSM encoding for the 2R1W register file
// Rev 1.0
// ============================================================================
package regfile_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_DEPTH = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_2r1w_if.sv
`default_nettype none
// ============================================================================
// regfile_2r1w_if : write, dual-read and clear bus of the 2R1W register file
// Rev 1.0
// ============================================================================
interface regfile_2r1w_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
);

  logic [WIDTH-1:0] data_in;
  logic [AW-1:0]    writenum;
  logic             write;
  logic [AW-1:0]    readnum_a;
  logic [AW-1:0]    readnum_b;
  logic [WIDTH-1:0] data_out_a;
  logic [WIDTH-1:0] data_out_b;
  logic             valid_a;
  logic             valid_b;
  logic             clear_req;
  logic             busy;

  modport master (
    output data_in, writenum, write, readnum_a, readnum_b, clear_req,
    input  data_out_a, data_out_b, valid_a, valid_b, busy
  );

  modport slave (
    input  data_in, writenum, write, readnum_a, readnum_b, clear_req,
    output data_out_a, data_out_b, valid_a, valid_b, busy
  );

endinterface
`default_nettype wire

// File: rtl/regfile_rdport.sv
`default_nettype none
// ============================================================================
// regfile_rdport : one read port - address mux, write bypass, optional flop
// Rev 1.0
// ============================================================================
module regfile_rdport #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int READ_REG = 0,
  parameter int BYPASS   = 1
) (
  input  wire logic                        clk,
  input  wire logic                        reset_n,
  input  wire logic [DEPTH-1:0][WIDTH-1:0] i_mem,
  input  wire logic [DEPTH-1:0]            i_vld,
  input  wire logic [AW-1:0]               i_addr,
  input  wire logic                        i_wr_en,
  input  wire logic [AW-1:0]               i_wr_addr,
  input  wire logic [WIDTH-1:0]            i_wr_data,
  output logic      [WIDTH-1:0]            o_data,
  output logic                             o_valid
);

  logic             w_in_range;
  logic             w_hit;
  logic [WIDTH-1:0] w_data;
  logic             w_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  assign w_in_range = ({1'b0, i_addr} < (AW+1)'(DEPTH));
  // i_wr_en is already qualified by reset, idle state and address range
  assign w_hit      = (BYPASS != 0) && i_wr_en && (i_wr_addr == i_addr);

  always_comb begin
    w_data  = '0;
    w_valid = 1'b0;
    if (w_hit) begin
      w_data  = i_wr_data;
      w_valid = 1'b1;
    end else if (w_in_range) begin
      w_data  = i_mem[i_addr];
      w_valid = i_vld[i_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_data  <= w_data;
      r_valid <= w_valid;
    end
  end

  assign o_data  = (READ_REG != 0) ? r_data  : w_data;
  assign o_valid = (READ_REG != 0) ? r_valid : w_valid;

endmodule
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
// regfile_2r1w : 2-read / 1-write register file with valid bits and clear sweep
// Rev 1.0
// ============================================================================
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter int READ_REG = 0,
  parameter int BYPASS   = 1
) (
  input  wire logic     clk,
  input  wire logic     reset_n,
  regfile_2r1w_if.slave bus
);

  localparam logic [AW-1:0] C_LAST = AW'(DEPTH - 1);

  state_t                      r_state;
  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [DEPTH-1:0]            r_vld;
  logic [AW-1:0]               r_cnt;
  logic                        w_wr_en;

  assign w_wr_en = reset_n && bus.write && (r_state == ST_IDLE) &&
                   ({1'b0, bus.writenum} < (AW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_mem   <= '0;
      r_vld   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_wr_en) begin
            r_mem[bus.writenum] <= bus.data_in;
            r_vld[bus.writenum] <= 1'b1;
          end
          // a coincident write commits now and is swept later in the pass
          if (bus.clear_req) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
          end
        end
        ST_CLEAR: begin
          r_mem[r_cnt] <= '0;
          r_vld[r_cnt] <= 1'b0;
          r_cnt        <= r_cnt + AW'(1);
          if (r_cnt == C_LAST) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state == ST_CLEAR);

  regfile_rdport #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .READ_REG(READ_REG), .BYPASS(BYPASS)
  ) u_rd_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_mem    (r_mem),
    .i_vld    (r_vld),
    .i_addr   (bus.readnum_a),
    .i_wr_en  (w_wr_en),
    .i_wr_addr(bus.writenum),
    .i_wr_data(bus.data_in),
    .o_data   (bus.data_out_a),
    .o_valid  (bus.valid_a)
  );

  regfile_rdport #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .READ_REG(READ_REG), .BYPASS(BYPASS)
  ) u_rd_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_mem    (r_mem),
    .i_vld    (r_vld),
    .i_addr   (bus.readnum_b),
    .i_wr_en  (w_wr_en),
    .i_wr_addr(bus.writenum),
    .i_wr_data(bus.data_in),
    .o_data   (bus.data_out_b),
    .o_valid  (bus.valid_b)
  );

endmodule
`default_nettype wire

// File: tb/tb_regfile_2r1w.sv
`default_nettype none
// ============================================================================
// tb_regfile_2r1w : three configurations driven in lockstep against an array model
// Rev 1.0
// ============================================================================
module tb_regfile_2r1w;

  localparam int W = 16;
  localparam int D = 8;
  localparam int A = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] data_in;
  logic [A-1:0] writenum, readnum_a, readnum_b;
  logic         write, clear_req;

  // if0: comb+bypass, if1: comb no bypass, if2: registered+bypass
  regfile_2r1w_if #(.WIDTH(W), .AW(A)) if0 (), if1 (), if2 ();

  assign if0.data_in = data_in;  assign if1.data_in = data_in;  assign if2.data_in = data_in;
  assign if0.writenum = writenum; assign if1.writenum = writenum; assign if2.writenum = writenum;
  assign if0.write = write;      assign if1.write = write;      assign if2.write = write;
  assign if0.readnum_a = readnum_a; assign if1.readnum_a = readnum_a; assign if2.readnum_a = readnum_a;
  assign if0.readnum_b = readnum_b; assign if1.readnum_b = readnum_b; assign if2.readnum_b = readnum_b;
  assign if0.clear_req = clear_req; assign if1.clear_req = clear_req; assign if2.clear_req = clear_req;

  regfile_2r1w #(.WIDTH(W), .DEPTH(D), .AW(A), .READ_REG(0), .BYPASS(1))
    dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  regfile_2r1w #(.WIDTH(W), .DEPTH(D), .AW(A), .READ_REG(0), .BYPASS(0))
    dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
  regfile_2r1w #(.WIDTH(W), .DEPTH(D), .AW(A), .READ_REG(1), .BYPASS(1))
    dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));

  logic [W-1:0] m_mem [D];
  logic         m_vld [D];
  int           m_sweep;
  logic [W:0]   exp_ra, exp_rb;
  int           checks = 0;
  int           errors = 0;

  function automatic logic [W:0] mread(input logic [A-1:0] addr, input bit byp);
    if (byp && reset_n && m_sweep < 0 && write && writenum == addr)
      return {1'b1, data_in};
    if (int'(addr) < D) return {m_vld[addr], m_mem[addr]};
    return '0;
  endfunction

  task automatic model_edge();
    if (!reset_n) begin
      for (int i = 0; i < D; i++) begin m_mem[i] = '0; m_vld[i] = 1'b0; end
      m_sweep = -1;
    end else if (m_sweep >= 0) begin
      m_mem[m_sweep] = '0;
      m_vld[m_sweep] = 1'b0;
      m_sweep++;
      if (m_sweep == D) m_sweep = -1;
    end else begin
      if (write && int'(writenum) < D) begin
        m_mem[writenum] = data_in;
        m_vld[writenum] = 1'b1;
      end
      if (clear_req) m_sweep = 0;
    end
  endtask

  task automatic drive(input logic w, input logic [A-1:0] wa, input logic [W-1:0] d,
                       input logic [A-1:0] ra, input logic [A-1:0] rb, input logic clr);
    write = w; writenum = wa; data_in = d; readnum_a = ra; readnum_b = rb; clear_req = clr;
  endtask

  // One clock: compare all ports against the model, then advance the model.
  task automatic tick();
    logic [W:0] ea, eb, ea0, eb0;
    logic       eb_busy;
    #1;
    ea  = mread(readnum_a, 1'b1); eb  = mread(readnum_b, 1'b1);
    ea0 = mread(readnum_a, 1'b0); eb0 = mread(readnum_b, 1'b0);
    eb_busy = (m_sweep >= 0);
    checks++; if ({if0.valid_a, if0.data_out_a} !== ea) begin errors++;
      $display("FAIL byp_a t=%0t got=%h exp=%h", $time, {if0.valid_a, if0.data_out_a}, ea); end
    checks++; if ({if0.valid_b, if0.data_out_b} !== eb) begin errors++;
      $display("FAIL byp_b t=%0t got=%h exp=%h", $time, {if0.valid_b, if0.data_out_b}, eb); end
    checks++; if ({if1.valid_a, if1.data_out_a} !== ea0) begin errors++;
      $display("FAIL nobyp_a t=%0t got=%h exp=%h", $time, {if1.valid_a, if1.data_out_a}, ea0); end
    checks++; if ({if1.valid_b, if1.data_out_b} !== eb0) begin errors++;
      $display("FAIL nobyp_b t=%0t got=%h exp=%h", $time, {if1.valid_b, if1.data_out_b}, eb0); end
    checks++; if ({if2.valid_a, if2.data_out_a} !== exp_ra) begin errors++;
      $display("FAIL reg_a t=%0t got=%h exp=%h", $time, {if2.valid_a, if2.data_out_a}, exp_ra); end
    checks++; if ({if2.valid_b, if2.data_out_b} !== exp_rb) begin errors++;
      $display("FAIL reg_b t=%0t got=%h exp=%h", $time, {if2.valid_b, if2.data_out_b}, exp_rb); end
    checks++; if ({if0.busy, if1.busy, if2.busy} !== {3{eb_busy}}) begin errors++;
      $display("FAIL busy t=%0t got=%b exp=%b", $time, {if0.busy, if1.busy, if2.busy}, eb_busy); end
    @(posedge clk);
    exp_ra = reset_n ? ea : '0;
    exp_rb = reset_n ? eb : '0;
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b1, 3'd2, 16'hDEAD, 3'd2, 3'd2, 1'b1);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < D; i++) begin
      drive(1'b0, 3'd0, 16'h0, A'(i), A'(i), 1'b0);
      #1;
      checks++; if ({if0.valid_a, if0.data_out_a, if0.valid_b, if0.data_out_b} !== 34'h0) begin
        errors++; $display("FAIL reset_read addr=%0d got=%h/%h exp=0", i,
                           {if0.valid_a, if0.data_out_a}, {if0.valid_b, if0.data_out_b}); end
      tick();
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 3'd0, 16'h8000, 3'd0, 3'd0, 1'b0); tick();
    drive(1'b1, 3'd1, 16'hFFFF, 3'd0, 3'd0, 1'b0); tick();
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd1, 1'b0);
    #1;
    checks++; if ({if0.valid_a, if0.data_out_a} !== 17'h18000) begin errors++;
      $display("FAIL wr_rd_a got=%h exp=18000", {if0.valid_a, if0.data_out_a}); end
    checks++; if ({if0.valid_b, if0.data_out_b} !== 17'h1FFFF) begin errors++;
      $display("FAIL wr_rd_b got=%h exp=1ffff", {if0.valid_b, if0.data_out_b}); end
    tick();
  endtask

  task automatic test_bypass();
    drive(1'b1, 3'd3, 16'h0BAD, 3'd0, 3'd0, 1'b0); tick();
    drive(1'b1, 3'd3, 16'h1234, 3'd3, 3'd0, 1'b0);
    #1;
    checks++; if ({if0.valid_a, if0.data_out_a} !== 17'h11234) begin errors++;
      $display("FAIL bypass_on got=%h exp=11234", {if0.valid_a, if0.data_out_a}); end
    checks++; if ({if1.valid_a, if1.data_out_a} !== 17'h10BAD) begin errors++;
      $display("FAIL bypass_off got=%h exp=10bad", {if1.valid_a, if1.data_out_a}); end
    tick();
    drive(1'b0, 3'd0, 16'h0, 3'd3, 3'd0, 1'b0);
    #1;
    checks++; if ({if2.valid_a, if2.data_out_a} !== 17'h11234) begin errors++;
      $display("FAIL bypass_reg got=%h exp=11234", {if2.valid_a, if2.data_out_a}); end
    tick();
  endtask

  task automatic test_reg_latency();
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0); tick();
    readnum_b = 3'd1;
    #1;
    checks++; if ({if2.valid_b, if2.data_out_b} !== 17'h18000) begin errors++;
      $display("FAIL lat_before got=%h exp=18000", {if2.valid_b, if2.data_out_b}); end
    tick();
    checks++; if ({if2.valid_b, if2.data_out_b} !== 17'h1FFFF) begin errors++;
      $display("FAIL lat_after got=%h exp=1ffff", {if2.valid_b, if2.data_out_b}); end
  endtask

  task automatic test_clear();
    int n;
    for (int i = 0; i < D; i++) begin
      drive(1'b1, A'(i), W'(16'h1100 + i), 3'd0, 3'd7, 1'b0); tick();
    end
    drive(1'b0, 3'd0, 16'h0, 3'd2, 3'd5, 1'b1); tick();
    clear_req = 1'b0;
    n = 0;
    while (if0.busy === 1'b1 && n < 20) begin
      write = (n == 4);
      writenum = 3'd2; data_in = 16'h7777;
      clear_req = (n == 6);
      tick();
      n++;
    end
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0);
    checks++; if (n != D) begin errors++;
      $display("FAIL clear_len got=%0d exp=%0d", n, D); end
    for (int i = 0; i < D; i++) begin
      readnum_a = A'(i); readnum_b = A'(i);
      #1;
      checks++; if ({if0.valid_a, if0.data_out_a, if1.valid_b, if1.data_out_b} !== 34'h0) begin
        errors++; $display("FAIL cleared addr=%0d got=%h/%h exp=0", i,
                           {if0.valid_a, if0.data_out_a}, {if1.valid_b, if1.data_out_b}); end
      tick();
    end
  endtask

  task automatic test_clear_with_write();
    int n;
    drive(1'b1, 3'd6, 16'h6666, 3'd6, 3'd6, 1'b1); tick();
    drive(1'b0, 3'd0, 16'h0, 3'd6, 3'd6, 1'b0);
    n = 0;
    while (m_sweep >= 0 && n < 20) begin tick(); n++; end
    #1;
    checks++; if ({if0.valid_a, if0.data_out_a} !== 17'h0) begin errors++;
      $display("FAIL clr_wr got=%h exp=0", {if0.valid_a, if0.data_out_a}); end
    tick();
  endtask

  task automatic test_reset_in_sweep();
    for (int i = 0; i < D; i++) begin
      drive(1'b1, A'(i), W'($urandom), 3'd0, 3'd0, 1'b0); tick();
    end
    drive(1'b0, 3'd0, 16'h0, 3'd6, 3'd7, 1'b1); tick();
    clear_req = 1'b0;
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    checks++; if ({if0.busy, if2.busy} !== 2'b00) begin errors++;
      $display("FAIL rst_sweep_busy got=%b exp=00", {if0.busy, if2.busy}); end
    reset_n = 1'b1;
    for (int i = 0; i < D; i++) begin
      readnum_a = A'(i); readnum_b = A'(i);
      #1;
      checks++; if ({if0.valid_a, if0.data_out_a} !== 17'h0) begin errors++;
        $display("FAIL rst_sweep_read addr=%0d got=%h exp=0", i, {if0.valid_a, if0.data_out_a}); end
      tick();
    end
    drive(1'b1, 3'd5, 16'h5A5A, 3'd0, 3'd0, 1'b0); tick();
    drive(1'b0, 3'd0, 16'h0, 3'd5, 3'd5, 1'b0);
    #1;
    checks++; if ({if0.valid_a, if0.data_out_a} !== 17'h15A5A) begin errors++;
      $display("FAIL post_rst_write got=%h exp=15a5a", {if0.valid_a, if0.data_out_a}); end
    tick();
  endtask

  task automatic test_random();
    int n;
    for (int k = 0; k < 300; k++) begin
      drive(1'($urandom_range(0, 1)), A'($urandom), W'($urandom), A'($urandom), A'($urandom),
            1'($urandom_range(0, 39) == 0));
      if ($urandom_range(0, 3) == 0) readnum_a = writenum;
      if ($urandom_range(0, 3) == 0) readnum_b = writenum;
      tick();
    end
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0);
    n = 0;
    while (m_sweep >= 0 && n < 20) begin tick(); n++; end
  endtask

  initial begin
    for (int i = 0; i < D; i++) begin m_mem[i] = '0; m_vld[i] = 1'b0; end
    m_sweep = -1;
    exp_ra = '0; exp_rb = '0;
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_write_read();
    test_bypass();
    test_reg_latency();
    test_clear();
    test_clear_with_write();
    test_random();
    test_reset_in_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits.
REQ-002 Parameter DEPTH, default 8: number of registers; legal range 2..256.
REQ-003 Parameter AW, default $clog2(DEPTH): address width.
REQ-004 Parameter READ_REG, default 0: 0 = combinational read; 1 = registered read with one-cycle latency.
REQ-005 Parameter BYPASS, default 1: 1 = forward write data to a read port that addresses the register being written.
REQ-006 Port clk  in  1  single clock; all state updates on the rising edge.
REQ-007 Port reset_n  in  1  reset, synchronous and active-low.
REQ-008 Port data_in  in  WIDTH  write data.
REQ-009 Port writenum  in  AW  write address.
REQ-010 Port write  in  1  write enable.
REQ-011 Port readnum_a / readnum_b  in  AW  read addresses, ports A and B.
REQ-012 Port data_out_a / data_out_b  out  WIDTH  read data, ports A and B.
REQ-013 Port valid_a / valid_b  out  1  addressed register has been written since the last reset or clear.
REQ-014 Port clear_req  in  1  single-cycle request to zero all registers.
REQ-015 Port busy  out  1  high while a clear sweep is in progress.

Function
REQ-016 Write: at a rising edge with write=1, busy=0 and writenum<DEPTH, reg[writenum] SHALL take data_in and vld[writenum] SHALL be set.
REQ-017 Out-of-range address (>=DEPTH): a write SHALL be ignored; a read SHALL return 0 with valid=0.
REQ-018 READ_REG=0: data_out_x and valid_x SHALL follow reg[readnum_x] and vld[readnum_x] combinationally.
REQ-019 READ_REG=1: data_out_x and valid_x SHALL present the value addressed at the previous rising edge (latency 1).
REQ-020 BYPASS=1 with write=1, busy=0, writenum==readnum_x: port x SHALL return data_in with valid=1 (same cycle if READ_REG=0, next cycle if READ_REG=1).
REQ-021 BYPASS=0: a read of the register being written SHALL return the old contents and the old valid bit.
REQ-022 Both ports MAY address the same register; each port SHALL return identical data.
REQ-023 FSM states: IDLE and CLEAR.
REQ-024 IDLE -> CLEAR on a rising edge with clear_req=1; the sweep counter SHALL load 0.
REQ-025 In CLEAR, each edge SHALL zero reg[cnt] and vld[cnt], then increment cnt.
REQ-026 CLEAR -> IDLE on the edge that clears entry DEPTH-1; the sweep SHALL take exactly DEPTH cycles.
REQ-027 busy SHALL be 1 exactly while state=CLEAR (registered, no combinational path from clear_req).
REQ-028 Writes during CLEAR SHALL be dropped; clear_req during CLEAR SHALL be ignored.
REQ-029 Reads during CLEAR SHALL return current storage, so entries not yet swept keep old data; bypass SHALL be inactive.
REQ-030 write and clear_req together in IDLE: the write SHALL commit, then the sweep SHALL zero that entry.

Reset
REQ-031 With reset_n=0 at a rising edge, all registers, vld bits, cnt, and any read-output registers SHALL become 0, and state SHALL become IDLE.
REQ-032 Reset SHALL override a sweep in progress; busy SHALL be 0 on the edge after reset is sampled.
REQ-033 While reset_n=0, write and clear_req SHALL have no effect.

Structure
REQ-034 State encoding (IDLE/CLEAR) and default WIDTH/DEPTH constants SHALL live in shared package regfile_pkg.
REQ-035 One sub-module, regfile_rdport, SHALL implement a single read port (mux, bypass, optional output register) and SHALL be instantiated twice.

Verification
REQ-036 Reset, then read all 8 addresses on both ports -> data 0x0000, valid 0.
REQ-037 Write 0x8000 to r0 and 0xFFFF to r1, then read A=0, B=1 -> A=0x8000, B=0xFFFF, both valid=1.
REQ-038 BYPASS=1, READ_REG=0: write 0x1234 to r3 with readnum_a=3 -> data_out_a=0x1234 in the same cycle; with BYPASS=0 -> previous r3 value.
REQ-039 READ_REG=1: set readnum_b=1 -> data_out_b updates exactly one edge later.
REQ-040 Fill r0..r7, then pulse clear_req -> busy high for exactly 8 cycles; a write to r2 during the sweep is dropped; afterwards all reads return 0 with valid=0.
REQ-041 Assert reset_n=0 in the 4th cycle of a sweep -> busy=0 on the next edge, all registers 0, state IDLE; a following write to r5 succeeds.
